// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, FSM states and byte-mask constants for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  // Size lives in the low two bits; bit 2 only selects zero extension.
  function automatic logic [3:0] mask_for(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   mask_for = MASK_B;
      2'b01:   mask_for = MASK_H;
      default: mask_for = MASK_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - rotates a memory word to the access offset and sign/zero-extends it
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] mdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [63:0] dbl;
  logic [31:0] rot;

  always_comb begin
    dbl = {mdata, mdata} >> {offset, 3'b000};
    rot = dbl[31:0];
    case (funct3)
      F3_B:    result = {{24{rot[7]}}, rot[7:0]};
      F3_BU:   result = {24'h0, rot[7:0]};
      F3_H:    result = {{16{rot[15]}}, rot[15:0]};
      F3_HU:   result = {16'h0, rot[15:0]};
      default: result = rot;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store FSM with stall timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err,
  output logic [31:0] O_rdata,
  output logic [31:0] O_maddr,
  output logic [31:0] O_mdata,
  output logic [3:0]  O_mmask,
  output logic        O_mwe,
  input  logic [31:0] I_mdata,
  input  logic        I_mstall
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        we_q, we_n;
  logic [2:0]  f3_q, f3_n;
  logic [1:0]  off_q, off_n;
  logic        err_q, err_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] rdata_n, maddr_n, mdata_n, aligned;
  logic [3:0]  mmask_n;
  logic        mwe_n;

  lsu_align u_align (
    .mdata  (I_mdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (aligned)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      err_q   <= 1'b0;
      cnt     <= '0;
      O_rdata <= 32'h0;
      O_maddr <= 32'h0;
      O_mdata <= 32'h0;
      O_mmask <= 4'h0;
      O_mwe   <= 1'b0;
    end else begin
      state   <= state_n;
      we_q    <= we_n;
      f3_q    <= f3_n;
      off_q   <= off_n;
      err_q   <= err_n;
      cnt     <= cnt_n;
      O_rdata <= rdata_n;
      O_maddr <= maddr_n;
      O_mdata <= mdata_n;
      O_mmask <= mmask_n;
      O_mwe   <= mwe_n;
    end
  end

  always_comb begin
    state_n = state;
    we_n    = we_q;
    f3_n    = f3_q;
    off_n   = off_q;
    err_n   = err_q;
    cnt_n   = cnt;
    rdata_n = O_rdata;
    maddr_n = O_maddr;
    mdata_n = O_mdata;
    mmask_n = O_mmask;
    mwe_n   = O_mwe;
    case (state)
      ST_IDLE: begin
        if (I_req) begin
          if (is_legal(I_funct3)) begin
            we_n    = I_we;
            f3_n    = I_funct3;
            off_n   = I_addr[1:0];
            err_n   = 1'b0;
            cnt_n   = '0;
            maddr_n = I_addr;
            mdata_n = I_wdata;
            mmask_n = mask_for(I_funct3);
            mwe_n   = I_we;
            state_n = ST_REQ;
          end else begin
            err_n   = 1'b1;
            state_n = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (I_mstall) begin
          // Abort on the stalled cycle that brings the counter to TIMEOUT.
          if (cnt >= CNT_LAST) begin
            cnt_n   = CNT_MAX;
            mwe_n   = 1'b0;
            mmask_n = 4'h0;
            err_n   = 1'b1;
            state_n = ST_DONE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          mmask_n = 4'h0;
          if (we_q) begin
            mwe_n   = 1'b0;
            state_n = ST_DONE;
          end else begin
            state_n = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rdata_n = aligned;
        state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign O_busy = (state != ST_IDLE);
  assign O_done = (state == ST_DONE);
  assign O_err  = O_done & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        I_clk, I_rst_n, I_req, I_we, I_mstall;
  logic [2:0]  I_funct3;
  logic [31:0] I_addr, I_wdata, I_mdata;
  logic        O_busy, O_done, O_err, O_mwe;
  logic [31:0] O_rdata, O_maddr, O_mdata;
  logic [3:0]  O_mmask;

  load_store_unit #(.TIMEOUT(15)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_req(I_req), .I_we(I_we),
    .I_funct3(I_funct3), .I_addr(I_addr), .I_wdata(I_wdata),
    .O_busy(O_busy), .O_done(O_done), .O_err(O_err), .O_rdata(O_rdata),
    .O_maddr(O_maddr), .O_mdata(O_mdata), .O_mmask(O_mmask), .O_mwe(O_mwe),
    .I_mdata(I_mdata), .I_mstall(I_mstall)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          stalls;
    int          exp_lat;
    logic        exp_err;
    logic [3:0]  exp_mask;
    int          exp_mwe;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          r_lat, r_mwe_go;
  logic        r_done, r_err;
  logic [31:0] r_rdata, r_maddr, r_mdata;
  logic [3:0]  r_mask;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata, input int stalls);
    int left;
    left     = stalls;
    I_req    = 1'b1;
    I_we     = we;
    I_funct3 = f3;
    I_addr   = addr;
    I_wdata  = wdata;
    I_mdata  = mdata;
    I_mstall = 1'b0;
    r_lat = 0; r_done = 1'b0; r_err = 1'b0; r_rdata = '0;
    r_mask = '0; r_maddr = '0; r_mdata = '0; r_mwe_go = 0;
    for (int c = 1; c <= 60 && !r_done; c++) begin
      tick();
      I_req = 1'b0;
      if (c == 1) begin
        r_mask  = O_mmask;
        r_maddr = O_maddr;
        r_mdata = O_mdata;
      end
      if (O_done) begin
        r_done  = 1'b1;
        r_lat   = c;
        r_err   = O_err;
        r_rdata = O_rdata;
      end
      I_mstall = (left > 0);
      if (left > 0) left--;
      // The next edge performs a write only if the enable is up and memory is ready.
      if (O_mwe && !I_mstall) r_mwe_go++;
    end
    I_mstall = 1'b0;
    if (!r_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout: no done within 60 cycles, required one");
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 32'h103,  32'h0,        32'h8A000000, 0,  3,  1'b0, 4'b0001, 0, 32'hFFFFFF8A};
    vecs[1]  = '{1'b0, 3'b100, 32'h103,  32'h0,        32'h8A000000, 0,  3,  1'b0, 4'b0001, 0, 32'h0000008A};
    vecs[2]  = '{1'b0, 3'b001, 32'h102,  32'h0,        32'h12345678, 0,  3,  1'b0, 4'b0011, 0, 32'h00001234};
    vecs[3]  = '{1'b0, 3'b010, 32'h101,  32'h0,        32'h12345678, 0,  3,  1'b0, 4'b1111, 0, 32'h78123456};
    vecs[4]  = '{1'b0, 3'b101, 32'h100,  32'h0,        32'h0000F00D, 0,  3,  1'b0, 4'b0011, 0, 32'h0000F00D};
    vecs[5]  = '{1'b0, 3'b001, 32'h100,  32'h0,        32'h0000F00D, 0,  3,  1'b0, 4'b0011, 0, 32'hFFFFF00D};
    vecs[6]  = '{1'b1, 3'b001, 32'h1003, 32'h0000ABCD, 32'h0,        0,  2,  1'b0, 4'b0011, 1, 32'hFFFFF00D};
    vecs[7]  = '{1'b1, 3'b010, 32'h40,   32'hDEADBEEF, 32'h0,        3,  5,  1'b0, 4'b1111, 1, 32'hFFFFF00D};
    vecs[8]  = '{1'b0, 3'b000, 32'h101,  32'h0,        32'h11228033, 2,  5,  1'b0, 4'b0001, 0, 32'hFFFFFF80};
    vecs[9]  = '{1'b0, 3'b011, 32'h4,    32'h0,        32'h0,        0,  1,  1'b1, 4'b0000, 0, 32'hFFFFFF80};
    vecs[10] = '{1'b1, 3'b110, 32'h8,    32'hFFFFFFFF, 32'h0,        0,  1,  1'b1, 4'b0000, 0, 32'hFFFFFF80};
    vecs[11] = '{1'b1, 3'b010, 32'h200,  32'h55AA55AA, 32'h0,        20, 16, 1'b1, 4'b1111, 0, 32'hFFFFFF80};

    I_rst_n = 1'b0; I_req = 1'b0; I_we = 1'b0; I_funct3 = 3'b000;
    I_addr = '0; I_wdata = '0; I_mdata = '0; I_mstall = 1'b0;
    tick();
    tick();
    check("reset_state", {O_busy, O_done, O_err, O_mwe, O_mmask, O_rdata, O_maddr[23:0]}, 64'h0);
    check("reset_mdata", {32'h0, O_mdata}, 64'h0);
    I_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].mdata, vecs[i].stalls);
      check($sformatf("v%0d_latency", i), 64'(r_lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_err", i), {63'h0, r_err}, {63'h0, vecs[i].exp_err});
      check($sformatf("v%0d_mask", i), {60'h0, r_mask}, {60'h0, vecs[i].exp_mask});
      check($sformatf("v%0d_mwe_writes", i), 64'(r_mwe_go), 64'(vecs[i].exp_mwe));
      check($sformatf("v%0d_rdata", i), {32'h0, r_rdata}, {32'h0, vecs[i].exp_rdata});
      if (vecs[i].exp_lat > 1) begin
        check($sformatf("v%0d_maddr", i), {32'h0, r_maddr}, {32'h0, vecs[i].addr});
        check($sformatf("v%0d_mdata", i), {32'h0, r_mdata}, {32'h0, vecs[i].wdata});
      end
      tick();
      check($sformatf("v%0d_idle_after", i), {62'h0, O_busy, O_mwe}, 64'h0);
    end

    // Request raised while in DONE must not start a new access.
    I_req = 1'b1; I_we = 1'b0; I_funct3 = 3'b011; I_addr = 32'h10;
    tick();
    check("illegal_done", {62'h0, O_done, O_err}, 64'h3);
    I_funct3 = 3'b010;
    tick();
    I_req = 1'b0;
    check("req_in_done_ignored", {59'h0, O_busy, O_mmask}, 64'h0);

    // Reset in RESP of a load.
    do_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
    tick();
    I_req = 1'b1; I_we = 1'b0; I_funct3 = 3'b010; I_addr = 32'h104; I_mdata = 32'hCAFEF00D;
    tick();
    I_req = 1'b0;
    tick();
    check("in_resp_busy", {63'h0, O_busy}, 64'h1);
    #2;
    I_rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {O_busy, O_done, O_err, O_mwe, O_mmask, 24'h0, O_maddr}, 64'h0);
    check("async_reset_data", {O_rdata, O_mdata}, 64'h0);
    tick();
    tick();
    check("no_done_in_reset", {62'h0, O_done, O_busy}, 64'h0);
    I_rst_n = 1'b1;
    do_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
    check("post_reset_lat", 64'(r_lat), 64'd3);
    check("post_reset_rdata", {32'h0, r_rdata}, 64'h78123456);
    check("post_reset_err", {63'h0, r_err}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
